divider8_seq: RTL and testbench

- Sequential 8-bit unsigned restoring divider.
- Computes quotient and remainder one bit per clock using a ripple-borrow subtractor, with a start/busy/done handshake.
- Serves as the inverse-arithmetic companion to the team's ripple-carry adder datapath blocks.
- Sits between a control FSM (issues operands) and the result consumer.

---
 rtl/divider8_seq_pkg.sv | 13 +
 rtl/divider8_seq_subtractor_ripple.sv | 23 ++
 rtl/divider8_seq.sv | 108 ++++++++++
 tb/tb_divider8_seq.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/divider8_seq_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package divider8_seq_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned CNT_W_DEF = $clog2(WIDTH_DEF) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/divider8_seq_subtractor_ripple.sv
// Combinational ripple-borrow subtractor: diff = a - b, bout set when a < b.
module subtractor_ripple #(
  parameter int unsigned W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         bout
);

  logic [W:0] br;

  always_comb begin
    br   = '0;
    diff = '0;
    for (int unsigned i = 0; i < W; i++) begin
      diff[i]  = a[i] ^ b[i] ^ br[i];
      br[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
    end
    bout = br[W];
  end

endmodule

// File: rtl/divider8_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock,
// with a start/busy/done handshake.
module divider8_seq
  import divider8_seq_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  state_t state, state_n;

  logic [WIDTH:0]   p;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dv;
  logic [CW-1:0]    cnt;
  logic             dz_cap;

  logic [WIDTH:0]   p_sh;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH:0]   t;
  logic             borrow;
  logic             take;
  logic [WIDTH:0]   p_nx;
  logic [WIDTH-1:0] q_nx;
  logic             accept;
  logic             last;

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (cnt == CW'(WIDTH - 1));

  subtractor_ripple #(.W(WIDTH + 1)) u_sub (
    .a    (p_sh),
    .b    ({1'b0, dv}),
    .diff (t),
    .bout (borrow)
  );

  // p[WIDTH] is always 0 after a step (P < divisor); folding it into take
  // keeps the decision exact for the full-width shifted value.
  always_comb begin
    p_sh = {p[WIDTH-1:0], q[WIDTH-1]};
    q_sh = {q[WIDTH-2:0], 1'b0};
    take = ~borrow | p[WIDTH];
    p_nx = take ? t : p_sh;
    q_nx = q_sh | {{(WIDTH-1){1'b0}}, take};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last)  state_n = DONE;
      DONE:    state_n = start ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p           <= '0;
      q           <= '0;
      dv          <= '0;
      cnt         <= '0;
      dz_cap      <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      p      <= '0;
      q      <= dividend;
      dv     <= divisor;
      cnt    <= '0;
      dz_cap <= (divisor == '0);
    end else if (state == RUN) begin
      p   <= p_nx;
      q   <= q_nx;
      cnt <= cnt + 1'b1;
      if (last) begin
        quotient    <= q_nx;
        remainder   <= p_nx[WIDTH-1:0];
        div_by_zero <= dz_cap;
      end
    end
  end

endmodule

// File: tb/tb_divider8_seq.sv
// Scoreboard bench for divider8_seq: stimulus pushes expected results,
// a monitor pops and compares on every done pulse.
module tb_divider8_seq;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient, remainder;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   pushed = 0;
  int   seen   = 0;

  divider8_seq #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compares every done pulse against the oldest expected entry.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      exp_t e;
      seen++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", div_by_zero, e.dz);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives start for one edge; optionally records the expected result.
  task automatic issue(input logic [7:0] a, input logic [7:0] b,
                       input bit push, input exp_t e);
    start = 1'b1;
    dividend = a;
    divisor = b;
    if (push) begin
      sb.push_back(e);
      pushed++;
    end
    step();
    start = 1'b0;
    dividend = 8'hA5;
    divisor = 8'h5A;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (done !== 1'b1) chk("done_timeout", 0, 1);
  endtask

  function automatic exp_t mk(input int q, input int r, input int dz);
    exp_t e;
    e.q = q[7:0];
    e.r = r[7:0];
    e.dz = dz[0];
    return e;
  endfunction

  function automatic exp_t ref_div(input logic [7:0] a, input logic [7:0] b);
    if (b == 0) return mk(255, a, 1);
    return mk(a / b, a % b, 0);
  endfunction

  initial begin
    int n;
    logic [7:0] ra, rb;

    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dz", div_by_zero, 0);
    rst = 1'b0;
    step();

    // 100/7 with cycle-accurate handshake checks
    issue(8'd100, 8'd7, 1'b1, mk(14, 2, 0));
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("busy_c%0d", i), busy, 1);
      chk($sformatf("nodone_c%0d", i), done, 0);
      step();
    end
    chk("done_c9", done, 1);
    chk("busy_c9", busy, 0);
    step();
    chk("done_one_cycle", done, 0);
    chk("q_held", quotient, 14);
    chk("r_held", remainder, 2);

    issue(8'd255, 8'd1, 1'b1, mk(255, 0, 0));
    wait_done(n);
    issue(8'd5, 8'd200, 1'b1, mk(0, 5, 0));
    wait_done(n);
    issue(8'd77, 8'd0, 1'b1, mk(255, 77, 1));
    wait_done(n);
    issue(8'd8, 8'd2, 1'b1, mk(4, 0, 0));
    wait_done(n);
    step();

    // start during RUN is ignored; then back-to-back start in DONE
    issue(8'd200, 8'd3, 1'b1, mk(66, 2, 0));
    step();
    step();
    step();
    start = 1'b1;
    dividend = 8'd9;
    divisor = 8'd4;
    step();
    start = 1'b0;
    dividend = 8'd0;
    divisor = 8'd0;
    wait_done(n);
    issue(8'd9, 8'd4, 1'b1, mk(2, 1, 0));
    chk("b2b_busy", busy, 1);
    wait_done(n);
    chk("b2b_latency", n + 1, 9);
    step();

    // reset mid-operation aborts with no done pulse
    issue(8'd100, 8'd7, 1'b0, mk(0, 0, 0));
    step();
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_q", quotient, 0);
    chk("abort_r", remainder, 0);
    chk("abort_dz", div_by_zero, 0);
    for (int i = 0; i < 12; i++) step();
    chk("abort_no_done", seen, pushed);
    issue(8'd100, 8'd7, 1'b1, mk(14, 2, 0));
    wait_done(n);

    // back-to-back random operands, reference from / and %
    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = (i % 17 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      issue(ra, rb, 1'b1, ref_div(ra, rb));
      wait_done(n);
    end
    step();
    step();

    chk("sb_empty", sb.size(), 0);
    chk("done_count", seen, pushed);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
